// File: rtl/intr_stim_pkg.sv
// Shared constants and types for the interrupt stimulus generator.
package intr_stim_pkg;

  localparam logic [4:0] OFF_FIRE   = 5'h00;
  localparam logic [4:0] OFF_PULSE  = 5'h04;
  localparam logic [4:0] OFF_DELAY  = 5'h08;
  localparam logic [4:0] OFF_MODE   = 5'h0C;
  localparam logic [4:0] OFF_CLEAR  = 5'h10;
  localparam logic [4:0] OFF_STATUS = 5'h14;
  localparam logic [4:0] OFF_PEND   = 5'h18;
  localparam logic [4:0] OFF_ACTIVE = 5'h1C;

  localparam int STAT_BUSY = 31;
  localparam int STAT_OVF  = 30;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACT} state_t;

  typedef struct packed {
    logic        re;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } iobus_req_t;

endpackage

// File: rtl/intr_stim_timer.sv
// Loadable saturating down-counter; done while the count is at or below one.
module intr_stim_timer #(
  parameter int CNT_W = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  // Loading N and leaving on done gives exactly N cycles in the state.
  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/intr_stim_gen.sv
// Interrupt stimulus generator: IO-bus registers, launch FSM, pend queue, level latch.
module intr_stim_gen
  import intr_stim_pkg::*;
#(
  parameter int          N_CH      = 32,
  parameter int          CNT_W     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter int          RST_PULSE = 4
)(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_iobus_re,
  input  logic            i_iobus_we,
  input  logic [3:0]      i_iobus_sel,
  input  logic [31:0]     i_iobus_addr,
  input  logic [31:0]     i_iobus_data,
  output logic [31:0]     o_iobus_data,
  output logic [N_CH-1:0] o_intrpt,
  output logic            o_busy
);

  iobus_req_t       req;
  logic             in_win, wr, rd, wr_fire;
  logic [4:0]       off;
  state_t           state;
  logic [N_CH-1:0]  mask, cur, cur_lvl, pend, lvl_latch, mode;
  logic [N_CH-1:0]  launch_mask, lvl_set, clr_mask;
  logic [CNT_W-1:0] pulse_len, delay, plen_lat, plen_eff, tmr_val;
  logic             overflow, launch, tmr_load, tmr_done;
  logic [31:0]      rdata_nxt;

  assign req = '{re: i_iobus_re, we: i_iobus_we, sel: i_iobus_sel,
                 addr: i_iobus_addr, data: i_iobus_data};

  assign in_win   = (req.addr[31:5] == BASE_ADDR[31:5]);
  assign off      = req.addr[4:0];
  assign wr       = req.we && in_win && (req.sel == 4'hF);
  assign rd       = req.re && in_win;
  assign wr_fire  = wr && (off == OFF_FIRE);
  assign mask     = req.data[N_CH-1:0];
  assign clr_mask = (wr && off == OFF_CLEAR) ? mask : '0;
  assign plen_eff = (pulse_len == '0) ? CNT_W'(1) : pulse_len;

  // In IDLE a fresh FIRE and any queued channels launch together.
  assign launch_mask = pend | (wr_fire ? mask : '0);
  assign launch      = (state == ST_IDLE) && (launch_mask != '0);
  assign o_busy      = (state != ST_IDLE) || (pend != '0);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = plen_eff;
    lvl_set  = '0;
    case (state)
      ST_IDLE: if (launch) begin
        tmr_load = 1'b1;
        if (delay != '0) tmr_val = delay;
        else             lvl_set = launch_mask & mode;
      end
      ST_WAIT: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = plen_lat;
        lvl_set  = cur_lvl;
      end
      default: ;
    endcase
  end

  intr_stim_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      cur       <= '0;
      cur_lvl   <= '0;
      plen_lat  <= '0;
      pend      <= '0;
      lvl_latch <= '0;
      overflow  <= 1'b0;
      o_intrpt  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (launch) begin
          cur      <= launch_mask;
          cur_lvl  <= launch_mask & mode;
          plen_lat <= plen_eff;
          pend     <= '0;
          state    <= (delay != '0) ? ST_WAIT : ST_ACT;
        end
        ST_WAIT: if (tmr_done) state <= ST_ACT;
        ST_ACT:  if (tmr_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (wr_fire && state != ST_IDLE) pend <= pend | mask;
      if (wr_fire && state != ST_IDLE && (pend & mask) != '0) overflow <= 1'b1;
      else if (rd && off == OFF_STATUS)                       overflow <= 1'b0;
      // Set after clear: a channel latching this cycle survives a same-cycle CLEAR.
      lvl_latch <= (lvl_latch & ~clr_mask) | lvl_set;
      o_intrpt  <= ((state == ST_ACT) ? cur : '0) | lvl_latch;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pulse_len <= CNT_W'(RST_PULSE);
      delay     <= '0;
      mode      <= '0;
    end else if (wr) begin
      case (off)
        OFF_PULSE: pulse_len <= req.data[CNT_W-1:0];
        OFF_DELAY: delay     <= req.data[CNT_W-1:0];
        OFF_MODE:  mode      <= mask;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_nxt = '0;
    case (off)
      OFF_PULSE:  rdata_nxt = 32'(pulse_len);
      OFF_DELAY:  rdata_nxt = 32'(delay);
      OFF_MODE:   rdata_nxt = 32'(mode);
      OFF_STATUS: begin
        rdata_nxt[STAT_BUSY] = o_busy;
        rdata_nxt[STAT_OVF]  = overflow;
      end
      OFF_PEND:   rdata_nxt = 32'(pend);
      OFF_ACTIVE: rdata_nxt = 32'(o_intrpt);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_iobus_data <= '0;
    else          o_iobus_data <= rd ? rdata_nxt : '0;
  end

endmodule

// File: tb/tb_intr_stim_gen.sv
// Directed bench for intr_stim_gen: launch timing, delay, level latch, queueing, bus decode, reset.
module tb_intr_stim_gen;

  localparam logic [31:0] BASE = 32'h0002_0000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        re = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, intr, d;
  logic        busy;
  int          n_run = 0, n_fail = 0;

  always #5 i_clk = ~i_clk;

  intr_stim_gen dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_iobus_re   (re),
    .i_iobus_we   (we),
    .i_iobus_sel  (sel),
    .i_iobus_addr (addr),
    .i_iobus_data (wdata),
    .o_iobus_data (rdata),
    .o_intrpt     (intr),
    .o_busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; the access is sampled at the next rising edge.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] s);
    we = 1'b1; addr = a; wdata = v; sel = s;
    @(negedge i_clk);
    we = 1'b0; sel = 4'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    re = 1'b1; addr = a;
    @(negedge i_clk);
    re = 1'b0;
    v = rdata;
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_intr", intr, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Default pulse of 4 cycles starting one cycle after the write edge
    bus_rd(BASE + 32'h04, d);
    chk("rst_plen", d, 32'd4);
    bus_wr(BASE + 32'h00, 32'h0000_0888, 4'hF);
    chk("t1_intr_n0", intr, 32'h0);
    chk("t1_busy_n0", 32'(busy), 32'h1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge i_clk);
      chk($sformatf("t1_intr_n%0d", n), intr, (n <= 4) ? 32'h888 : 32'h0);
      chk($sformatf("t1_busy_n%0d", n), 32'(busy), (n <= 3) ? 32'h1 : 32'h0);
    end

    // DELAY=3, PULSE_LEN=0 behaves as 1: high only at the fourth cycle
    bus_wr(BASE + 32'h08, 32'd3, 4'hF);
    bus_wr(BASE + 32'h04, 32'd0, 4'hF);
    bus_wr(BASE + 32'h00, 32'h1, 4'hF);
    for (int n = 1; n <= 6; n++) begin
      @(negedge i_clk);
      chk($sformatf("t2_intr_n%0d", n), intr, (n == 4) ? 32'h1 : 32'h0);
    end

    // Level channel 16 latches; others pulse
    bus_wr(BASE + 32'h04, 32'd4, 4'hF);
    bus_wr(BASE + 32'h08, 32'd0, 4'hF);
    bus_wr(BASE + 32'h0C, 32'h0001_0000, 4'hF);
    bus_wr(BASE + 32'h00, 32'hFFFF_0000, 4'hF);
    for (int n = 1; n <= 7; n++) begin
      @(negedge i_clk);
      chk($sformatf("t3_intr_n%0d", n), intr, (n <= 4) ? 32'hFFFF_0000 : 32'h0001_0000);
    end
    bus_wr(BASE + 32'h10, 32'h0001_0000, 4'hF);
    chk("t3_clr_n0", intr, 32'h0001_0000);
    @(negedge i_clk);
    chk("t3_clr_n1", intr, 32'h0);
    bus_rd(BASE + 32'h1C, d);
    chk("t3_active", d, 32'h0);
    bus_wr(BASE + 32'h0C, 32'h0, 4'hF);

    // Queued FIRE during ACT, overflow set then cleared by STATUS read
    bus_wr(BASE + 32'h04, 32'd10, 4'hF);
    bus_wr(BASE + 32'h00, 32'h8, 4'hF);      // edge k
    bus_wr(BASE + 32'h00, 32'h80, 4'hF);     // k+1
    bus_rd(BASE + 32'h18, d);                // k+2
    chk("t4_pend", d, 32'h80);
    chk("t4_intr_n2", intr, 32'h8);
    bus_wr(BASE + 32'h00, 32'h80, 4'hF);     // k+3
    bus_rd(BASE + 32'h14, d);                // k+4
    chk("t4_status_ovf", d, 32'hC000_0000);
    bus_rd(BASE + 32'h14, d);                // k+5
    chk("t4_status_clr", d, 32'h8000_0000);
    for (int n = 6; n <= 23; n++) begin
      @(negedge i_clk);
      chk($sformatf("t4_intr_n%0d", n), intr,
          (n <= 10) ? 32'h8 : (n == 11) ? 32'h0 : (n <= 21) ? 32'h80 : 32'h0);
      if (n == 11) chk("t4_busy_gap", 32'(busy), 32'h1);
      if (n == 23) chk("t4_busy_end", 32'(busy), 32'h0);
    end

    // Partial byte-enable write ignored; out-of-window reads return 0
    bus_wr(BASE + 32'h00, 32'h1, 4'h3);
    for (int n = 0; n <= 3; n++) begin
      chk($sformatf("t5_intr_n%0d", n), intr, 32'h0);
      chk($sformatf("t5_busy_n%0d", n), 32'(busy), 32'h0);
      @(negedge i_clk);
    end
    bus_rd(32'h0003_0000, d);
    chk("t5_rd_outside", d, 32'h0);
    bus_rd(32'h0003_0004, d);
    chk("t5_rd_alias", d, 32'h0);
    bus_rd(BASE + 32'h04, d);
    chk("t5_rd_plen", d, 32'd10);
    @(negedge i_clk);
    chk("t5_rdata_idle", rdata, 32'h0);

    // Reset in the middle of ACT
    bus_wr(BASE + 32'h0C, 32'h3, 4'hF);
    bus_wr(BASE + 32'h00, 32'h3, 4'hF);
    @(negedge i_clk);
    chk("t6_intr_n1", intr, 32'h3);
    @(negedge i_clk);
    chk("t6_intr_n2", intr, 32'h3);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("t6_intr_rst", intr, 32'h0);
    chk("t6_busy_rst", 32'(busy), 32'h0);
    i_rst_n = 1'b1;
    bus_rd(BASE + 32'h04, d);
    chk("t6_plen", d, 32'd4);
    bus_rd(BASE + 32'h0C, d);
    chk("t6_mode", d, 32'h0);
    chk("t6_intr_after", intr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_stim_gen.md
# intr_stim_gen

Synthesizable, parametrised interrupt stimulus generator on the Otter IO bus. Firmware or a bench writes a channel mask and the block drives `o_intrpt` into the SoC's `i_intrpt` with a programmable delay, pulse length and per-channel pulse/level mode. A fire request that arrives while a pulse is in progress is queued, not dropped. It decodes its own register window and returns registered read data, so it serves both hardware-in-the-loop interrupt tests and self-checking simulation.

## Interface
Parameters:
- `N_CH`, 32: number of interrupt channels (1..32).
- `CNT_W`, 8: width of the delay and pulse-length counters.
- `BASE_ADDR`, 32'h0002_0000: register window base, 32-byte aligned.
- `RST_PULSE`, 4: reset value of PULSE_LEN.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  synchronous reset, active low.
- `i_iobus_re`  in  1  read strobe.
- `i_iobus_we`  in  1  write strobe.
- `i_iobus_sel`  in  4  byte enables.
- `i_iobus_addr`  in  32  byte address.
- `i_iobus_data`  in  32  write data.
- `o_iobus_data`  out  32  read data, registered.
- `o_intrpt`  out  N_CH  interrupt lines to the core.
- `o_busy`  out  1  FSM is not in IDLE, or PEND is non-zero.

## Operation
Register map, offset from BASE_ADDR:
- 0x00 FIRE (W): mask of channels to launch. Bits at or above N_CH are ignored.
- 0x04 PULSE_LEN (R/W, CNT_W bits): assertion length in cycles. A value of 0 behaves as 1.
- 0x08 DELAY (R/W, CNT_W bits): cycles from launch to assertion.
- 0x0C MODE (R/W, N_CH bits): per channel, 0 = pulse, 1 = level.
- 0x10 CLEAR (W1C): deasserts the latched level channels given in the mask.
- 0x14 STATUS (R): {o_busy, overflow, 30'b0}. A read clears `overflow`.
- 0x18 PEND (R): queued mask. 0x1C ACTIVE (R): current o_intrpt.

Bus rules:
- Only accesses whose address is inside the window are decoded.
- Writes are accepted only with `sel == 4'hF`; other writes are ignored.
- Reads of undecoded offsets, and any address outside the window, return 0.

FSM states:
- IDLE: on a FIRE write with non-zero mask, load `cur` and go to WAIT if DELAY≠0, otherwise go to ACT. If PEND≠0, pop all of PEND into `cur`, using the same rule.
- WAIT: count DELAY cycles, then go to ACT.
- ACT: drive `cur` for max(PULSE_LEN,1) cycles, then go to IDLE. At entry to ACT, the level-mode bits of `cur` are ORed into `lvl_latch`.

Output and queueing:
- `o_intrpt` = (ACT ? cur : 0) | lvl_latch.
- FIRE while not IDLE: PEND |= mask. If PEND & mask was already non-zero, set `overflow` (sticky).
- A FIRE and a CLEAR in the same cycle are impossible, since there is one bus access per cycle.
- A CLEAR of a bit that is entering `lvl_latch` in the same cycle: the set wins.
- PULSE_LEN, DELAY and MODE writes take effect at the next launch. The current operation keeps its latched values.

## Timing
- Write sampled at rising edge k. The register updates at edge k.
- FIRE with DELAY=0 from IDLE: `o_intrpt` is high from edge k+1 through edge k+1+PULSE_LEN, i.e. PULSE_LEN cycles.
- With DELAY=D, assertion begins at edge k+1+D.
- Back-to-back launches from PEND: exactly one IDLE cycle between the end of ACT and the next WAIT or ACT.
- Read: `o_iobus_data` is valid the cycle after the `re` cycle. It holds 0 when there is no read.
- Reset (`i_rst_n` = 0 at an edge): the FSM goes to IDLE. `cur`, PEND, `lvl_latch`, `overflow`, `o_intrpt`, `o_busy` and `o_iobus_data` all go to 0. PULSE_LEN = RST_PULSE, DELAY = 0, MODE = 0.
- Reset mid-pulse drops the lines on the next edge.
- Counters are CNT_W-bit down-counters with no wrap. PULSE_LEN = 2^CNT_W−1 is the maximum.

## Structure
- Package `intr_stim_pkg`:
  - register offset constants (`OFF_FIRE` … `OFF_ACTIVE`);
  - the FSM enum `{ST_IDLE, ST_WAIT, ST_ACT}`;
  - the STATUS bit positions.
- Sub-module `intr_stim_timer`: a loadable CNT_W down-counter with a `done` output. It is instantiated once and reused for both WAIT and ACT.
- Target size: top level about 200 lines, timer about 40 lines.

## Test plan
- Reset, then FIRE 0x0000_0888 with defaults → o_intrpt = 0x888 for exactly 4 cycles starting 1 cycle after the write. o_busy = 1 for 4 cycles.
- DELAY=3, PULSE_LEN=0, FIRE 0x1 → bit0 high for 1 cycle, 4 cycles after the write.
- MODE=0x0001_0000, FIRE 0xFFFF_0000 → bits 31:17 drop after the pulse, bit 16 stays high. CLEAR 0x0001_0000 → bit 16 low next cycle. ACTIVE reads back 0.
- PULSE_LEN=10, FIRE 0x8 then FIRE 0x80 during ACT → second pulse starts after one IDLE cycle. PEND reads 0x80 before that. A repeated FIRE 0x80 sets overflow, and a STATUS read clears it.
- Write FIRE with sel=4'h3, and a read of 0x0003_0000 → no pulse, and the read returns 0.
- Assert `i_rst_n` low mid-ACT → o_intrpt = 0 on the next edge, and PULSE_LEN reads back 4.
